// File: rtl/prbs_pkg.sv
// -----------------------------------------------------------------------------
// prbs_pkg
// Shared definitions for the PRBS transmit generator and its receive-side
// checker:
//   - ST_IDLE / ST_RUN : FSM state encoding
//   - COUNT_W          : width of the bit and error counters
//   - prbs_len_legal() : supported LFSR lengths
//   - prbs_tap()       : feedback tap for each supported length
// -----------------------------------------------------------------------------
package prbs_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int COUNT_W = 64;

    function automatic bit prbs_len_legal(input int n);
        return (n == 7) || (n == 9) || (n == 15) || (n == 23) || (n == 31);
    endfunction

    // Second tap of the two-tap polynomial x^n + x^tap + 1.
    function automatic int prbs_tap(input int n);
        case (n)
            7:       return 6;
            9:       return 5;
            15:      return 14;
            23:      return 18;
            31:      return 28;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/prbs_tx_gen_if.sv
// -----------------------------------------------------------------------------
// prbs_tx_gen_if
// Control and status bundle of the PRBS transmit generator.
//   i_enb_tx       transmitter enable
//   i_enable       symbol-rate strobe
//   i_err_period   periodic injection period in bits (0 = off)
//   i_err_single   single-shot injection request pulse
//   o_PRBS         registered serial PRBS bit
//   o_valid        one-cycle pulse: o_PRBS updated
//   o_period_sync  one-cycle pulse on the first bit of each pattern period
//   o_bits_count   bits transmitted since reset/restart
//   o_error_count  bits inverted since reset/restart
// master: the side driving the controls; slave: the generator.
// -----------------------------------------------------------------------------
interface prbs_tx_gen_if
    import prbs_pkg::*;
#(
    parameter int NB_PERIOD = 32
);

    logic                 i_enb_tx;
    logic                 i_enable;
    logic [NB_PERIOD-1:0] i_err_period;
    logic                 i_err_single;
    logic                 o_PRBS;
    logic                 o_valid;
    logic                 o_period_sync;
    logic [COUNT_W-1:0]   o_bits_count;
    logic [COUNT_W-1:0]   o_error_count;

    modport master (
        output i_enb_tx, i_enable, i_err_period, i_err_single,
        input  o_PRBS, o_valid, o_period_sync, o_bits_count, o_error_count
    );

    modport slave (
        input  i_enb_tx, i_enable, i_err_period, i_err_single,
        output o_PRBS, o_valid, o_period_sync, o_bits_count, o_error_count
    );

endinterface

// File: rtl/prbs_lfsr.sv
// -----------------------------------------------------------------------------
// prbs_lfsr
// Fibonacci LFSR for the polynomial x^N + x^TAP + 1. The serial output bit is
// o_state[N-1]. Shared by the transmit generator and the receive checker.
//   clock     system clock
//   i_reset   asynchronous active-low reset, loads SEED
//   i_load    synchronous load of i_seed (priority over i_step)
//   i_step    advance the register by one bit
//   i_seed    value taken on i_load
//   o_state   current register contents
// -----------------------------------------------------------------------------
module prbs_lfsr #(
    parameter int            N    = 9,
    parameter int            TAP  = 5,
    parameter logic [N-1:0]  SEED = {N{1'b1}}
) (
    input  logic         clock,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic         i_step,
    input  logic [N-1:0] i_seed,
    output logic [N-1:0] o_state
);

    logic [N-1:0] state;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= SEED;
        end else if (i_load) begin
            state <= i_seed;
        end else if (i_step) begin
            state <= {state[N-2:0], state[N-1] ^ state[TAP-1]};
        end
    end

    assign o_state = state;

endmodule

// File: rtl/prbs_tx_gen.sv
// -----------------------------------------------------------------------------
// prbs_tx_gen
// Transmit-side PRBS pattern generator with periodic and single-shot error
// injection and 64-bit transmitted-bit / injected-error counters.
//   clock         system clock
//   i_reset       asynchronous active-low reset
//   i_reset_sinc  synchronous restart (same effect as reset, at the edge)
//   bus           prbs_tx_gen_if.slave: enable, strobe, injection controls,
//                 serial output, valid/sync pulses and counters
// -----------------------------------------------------------------------------
module prbs_tx_gen
    import prbs_pkg::*;
#(
    parameter int                PRBS_N    = 9,
    parameter logic [PRBS_N-1:0] SEED      = {PRBS_N{1'b1}},
    parameter int                NB_PERIOD = 32
) (
    input  logic            clock,
    input  logic            i_reset,
    input  logic            i_reset_sinc,
    prbs_tx_gen_if.slave    bus
);

    localparam int                   TAP        = prbs_tap(PRBS_N);
    localparam logic [NB_PERIOD-1:0] PERIOD_ONE = {{(NB_PERIOD-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0]   COUNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

    if (!prbs_len_legal(PRBS_N)) begin : g_bad_len
        $error("prbs_tx_gen: PRBS_N=%0d is not a supported length", PRBS_N);
    end

    if (SEED == '0) begin : g_bad_seed
        $error("prbs_tx_gen: SEED must be nonzero");
    end

    logic [0:0]           state;
    logic                 step;
    logic [PRBS_N-1:0]    lfsr_state;
    logic [NB_PERIOD-1:0] period_cnt;
    logic [NB_PERIOD-1:0] period_prev;
    logic                 period_changed;
    logic                 period_hit;
    logic                 single_arm;
    logic                 invert;
    logic                 prbs_q;
    logic                 valid_q;
    logic                 sync_q;
    logic [COUNT_W-1:0]   bits_cnt;
    logic [COUNT_W-1:0]   error_cnt;

    // The restart input suppresses a step in the same cycle.
    assign step = (state == ST_RUN) && bus.i_enb_tx && bus.i_enable && !i_reset_sinc;

    assign period_changed = (bus.i_err_period != period_prev);
    assign period_hit     = (bus.i_err_period != '0) &&
                            (period_cnt == (bus.i_err_period - PERIOD_ONE));

    // A request arriving in the same cycle as a step applies to that step.
    // Periodic and single-shot hits on one bit still invert it only once.
    assign invert = period_hit || single_arm || bus.i_err_single;

    prbs_lfsr #(
        .N    (PRBS_N),
        .TAP  (TAP),
        .SEED (SEED)
    ) u_lfsr (
        .clock   (clock),
        .i_reset (i_reset),
        .i_load  (i_reset_sinc),
        .i_step  (step),
        .i_seed  (SEED),
        .o_state (lfsr_state)
    );

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= ST_IDLE;
        end else if (i_reset_sinc) begin
            state <= ST_IDLE;
        end else if ((state == ST_IDLE) && bus.i_enb_tx) begin
            state <= ST_RUN;
        end else if ((state == ST_RUN) && !bus.i_enb_tx) begin
            state <= ST_IDLE;
        end
    end

    // Any change of the period value restarts the period count on the next
    // cycle, so a new period is always measured from a clean start.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            period_prev <= '0;
            period_cnt  <= '0;
        end else begin
            period_prev <= bus.i_err_period;
            if (i_reset_sinc || period_changed) begin
                period_cnt <= '0;
            end else if (step && (bus.i_err_period != '0)) begin
                period_cnt <= period_hit ? '0 : period_cnt + PERIOD_ONE;
            end
        end
    end

    // Extra requests while already armed are absorbed.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            single_arm <= 1'b0;
        end else if (i_reset_sinc || step) begin
            single_arm <= 1'b0;
        end else if (bus.i_err_single) begin
            single_arm <= 1'b1;
        end
    end

    // The sync pulse marks the step that emits the first bit of the pattern,
    // i.e. the one whose pre-step LFSR contents equal SEED.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            prbs_q    <= 1'b0;
            valid_q   <= 1'b0;
            sync_q    <= 1'b0;
            bits_cnt  <= '0;
            error_cnt <= '0;
        end else if (i_reset_sinc) begin
            prbs_q    <= 1'b0;
            valid_q   <= 1'b0;
            sync_q    <= 1'b0;
            bits_cnt  <= '0;
            error_cnt <= '0;
        end else begin
            valid_q <= step;
            sync_q  <= step && (lfsr_state == SEED);
            if (step) begin
                prbs_q   <= lfsr_state[PRBS_N-1] ^ invert;
                bits_cnt <= bits_cnt + COUNT_ONE;
                if (invert) begin
                    error_cnt <= error_cnt + COUNT_ONE;
                end
            end
        end
    end

    assign bus.o_PRBS        = prbs_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_period_sync = sync_q;
    assign bus.o_bits_count  = bits_cnt;
    assign bus.o_error_count = error_cnt;

endmodule
